// File: rtl/cond_issue_stage.sv
// Conditional issue stage: holds NZCV, evaluates condition codes against it,
// forwards passing instructions to the ALU and stalls on in-flight flag writers.
module cond_issue_stage #(
  parameter int DATA_W   = 32,
  parameter int MAX_PEND = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_cond,
  input  logic                     in_setflags,
  input  logic [3:0]               in_opcode,
  input  logic signed [DATA_W-1:0] in_a,
  input  logic signed [DATA_W-1:0] in_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [3:0]               out_opcode,
  output logic signed [DATA_W-1:0] out_a,
  output logic signed [DATA_W-1:0] out_b,
  output logic                     out_setflags,
  output logic                     squash,
  input  logic                     wb_flag_valid,
  input  logic [3:0]               wb_flags,
  output logic [3:0]               flags,
  output logic [15:0]              stall_cycles,
  output logic                     err_underflow
);

  localparam int PW = $clog2(MAX_PEND + 1);
  localparam logic [PW-1:0] PEND_FULL = PW'(MAX_PEND);

  typedef enum logic [1:0] {IDLE, ISSUED, HAZARD} state_t;

  state_t                     state_q, state_d;
  logic [PW-1:0]              pend_cnt_q, pend_cnt_d;
  logic [3:0]                 flags_q, flags_d;
  logic                       out_valid_q, out_valid_d;
  logic [3:0]                 out_opcode_q, out_opcode_d;
  logic signed [DATA_W-1:0]   out_a_q, out_a_d;
  logic signed [DATA_W-1:0]   out_b_q, out_b_d;
  logic                       out_setflags_q, out_setflags_d;
  logic                       squash_q, squash_d;
  logic [15:0]                stall_q, stall_d;
  logic                       err_q, err_d;

  logic                       wb_dec;
  logic [PW-1:0]              eff_pend;
  logic [3:0]                 eff_flags;
  logic                       pass, hazard, cap_stall, accept, acc_pass, acc_fail;

  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'b0000: cond_pass = 1'b1;
      4'b0001: cond_pass = z;
      4'b0010: cond_pass = !z && (n == v);
      4'b0011: cond_pass = (n != v);
      4'b0100: cond_pass = (n == v);
      4'b0101: cond_pass = z || (n != v);
      4'b0110: cond_pass = cf && !z;
      4'b0111: cond_pass = !cf;
      4'b1000: cond_pass = cf;
      default: cond_pass = 1'b0;
    endcase
  endfunction

  // Writeback bypass: a flag result arriving this cycle is visible to this cycle's decision.
  assign wb_dec    = wb_flag_valid && (pend_cnt_q != '0);
  assign eff_pend  = pend_cnt_q - PW'(wb_dec);
  assign eff_flags = wb_flag_valid ? wb_flags : flags_q;
  assign pass      = cond_pass(in_cond, eff_flags);
  assign hazard    = in_valid && (in_cond != 4'b0000) && (eff_pend != '0);
  assign cap_stall = in_setflags && (eff_pend == PEND_FULL);
  assign in_ready  = !flush && (!out_valid_q || out_ready) && !hazard && !cap_stall;
  assign accept    = in_valid && in_ready;
  assign acc_pass  = accept && pass;
  assign acc_fail  = accept && !pass;

  always_comb begin
    state_d        = state_q;
    pend_cnt_d     = pend_cnt_q;
    out_valid_d    = out_valid_q;
    out_opcode_d   = out_opcode_q;
    out_a_d        = out_a_q;
    out_b_d        = out_b_q;
    out_setflags_d = out_setflags_q;
    squash_d       = 1'b0;
    flags_d        = eff_flags;
    err_d          = err_q | (wb_flag_valid && (pend_cnt_q == '0));
    stall_d        = stall_q;
    if (state_q == HAZARD && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;

    if (flush) begin
      state_d     = IDLE;
      pend_cnt_d  = '0;
      out_valid_d = 1'b0;
    end else begin
      pend_cnt_d = eff_pend + PW'(acc_pass && in_setflags);
      squash_d   = acc_fail;
      if (acc_pass) begin
        out_valid_d    = 1'b1;
        out_opcode_d   = in_opcode;
        out_a_d        = in_a;
        out_b_d        = in_b;
        out_setflags_d = in_setflags;
      end else if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end
      // HAZARD tracks a held, blocked instruction; out_valid drains independently of it.
      if (hazard)           state_d = HAZARD;
      else if (out_valid_d) state_d = ISSUED;
      else                  state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      pend_cnt_q     <= '0;
      flags_q        <= 4'b0000;
      out_valid_q    <= 1'b0;
      out_opcode_q   <= 4'b0000;
      out_a_q        <= '0;
      out_b_q        <= '0;
      out_setflags_q <= 1'b0;
      squash_q       <= 1'b0;
      stall_q        <= 16'd0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      pend_cnt_q     <= pend_cnt_d;
      flags_q        <= flags_d;
      out_valid_q    <= out_valid_d;
      out_opcode_q   <= out_opcode_d;
      out_a_q        <= out_a_d;
      out_b_q        <= out_b_d;
      out_setflags_q <= out_setflags_d;
      squash_q       <= squash_d;
      stall_q        <= stall_d;
      err_q          <= err_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_opcode    = out_opcode_q;
  assign out_a         = out_a_q;
  assign out_b         = out_b_q;
  assign out_setflags  = out_setflags_q;
  assign squash        = squash_q;
  assign flags         = flags_q;
  assign stall_cycles  = stall_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_cond_issue_stage.sv
// Bench for cond_issue_stage: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of the stage.
module tb_cond_issue_stage;
  localparam int DW = 32;
  localparam int MP = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush, in_valid, in_ready, in_setflags, out_valid, out_ready;
  logic out_setflags, squash, wb_flag_valid, err_underflow;
  logic [3:0] in_cond, in_opcode, out_opcode, wb_flags, flags;
  logic signed [DW-1:0] in_a, in_b, out_a, out_b;
  logic [15:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [3:0] m_flags;
  int m_pend, m_stall;
  logic m_ov, m_sf, m_sq, m_err, m_hz;
  logic [3:0] m_op;
  logic [DW-1:0] m_a, m_b;

  cond_issue_stage #(.DATA_W(DW), .MAX_PEND(MP)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_cond(in_cond),
    .in_setflags(in_setflags), .in_opcode(in_opcode), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
    .out_a(out_a), .out_b(out_b), .out_setflags(out_setflags), .squash(squash),
    .wb_flag_valid(wb_flag_valid), .wb_flags(wb_flags), .flags(flags),
    .stall_cycles(stall_cycles), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  function automatic bit m_cond(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cf, v;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c)
      4'd0: return 1'b1;
      4'd1: return z;
      4'd2: return !z && (n == v);
      4'd3: return n != v;
      4'd4: return n == v;
      4'd5: return z || (n != v);
      4'd6: return cf && !z;
      4'd7: return !cf;
      4'd8: return cf;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int m_eff_pend();
    return m_pend - ((wb_flag_valid && m_pend > 0) ? 1 : 0);
  endfunction

  function automatic bit m_ready();
    int ep;
    ep = m_eff_pend();
    if (flush) return 1'b0;
    if (m_ov && !out_ready) return 1'b0;
    if (in_valid && in_cond != 4'd0 && ep != 0) return 1'b0;
    if (in_setflags && ep == MP) return 1'b0;
    return 1'b1;
  endfunction

  task automatic m_reset();
    m_flags = 4'd0; m_pend = 0; m_stall = 0; m_ov = 1'b0; m_sf = 1'b0;
    m_sq = 1'b0; m_err = 1'b0; m_hz = 1'b0; m_op = 4'd0; m_a = '0; m_b = '0;
  endtask

  task automatic idle();
    in_valid = 1'b0; flush = 1'b0; wb_flag_valid = 1'b0; in_cond = 4'd0;
    in_setflags = 1'b0; in_opcode = 4'd0; in_a = '0; in_b = '0;
    wb_flags = 4'd0; out_ready = 1'b1;
  endtask

  // One clock: the model consumes the same inputs the DUT sees at the rising edge.
  task automatic tick();
    int ep;
    bit hz, acc, ps;
    logic [3:0] ef;
    @(posedge clk);
    ep  = m_eff_pend();
    ef  = wb_flag_valid ? wb_flags : m_flags;
    hz  = in_valid && in_cond != 4'd0 && ep != 0;
    acc = in_valid && m_ready();
    ps  = m_cond(in_cond, ef);
    if (wb_flag_valid && m_pend == 0) m_err = 1'b1;
    m_flags = ef;
    if (m_hz && m_stall < 65535) m_stall++;
    m_hz = hz && !flush;
    if (flush) begin
      m_pend = 0; m_ov = 1'b0; m_sq = 1'b0;
    end else begin
      m_pend = ep + ((acc && ps && in_setflags) ? 1 : 0);
      m_sq = acc && !ps;
      if (acc && ps) begin
        m_ov = 1'b1; m_op = in_opcode; m_a = in_a; m_b = in_b; m_sf = in_setflags;
      end else if (m_ov && out_ready) begin
        m_ov = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (flags !== 4'd0) begin errors++; $display("FAIL reset_flags: got %b expected 0000", flags); end
    checks++; if ({out_opcode, out_a, out_b, out_setflags} !== '0) begin errors++; $display("FAIL reset_out_data: got %h/%h/%h expected 0", out_opcode, out_a, out_b); end
    checks++; if ({squash, err_underflow, stall_cycles} !== '0) begin errors++; $display("FAIL reset_status: got sq=%b err=%b stall=%0d expected 0", squash, err_underflow, stall_cycles); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_pass();
    in_valid = 1'b1; in_cond = 4'd0; in_opcode = 4'd1; in_a = 5; in_b = 3;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready: got %b expected 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid: got %b expected 1", out_valid); end
    checks++; if (out_a !== 5 || out_b !== 3 || out_opcode !== 4'd1) begin errors++; $display("FAIL basic_out_data: got a=%0d b=%0d op=%0d expected 5 3 1", out_a, out_b, out_opcode); end
    checks++; if (flags !== 4'd0) begin errors++; $display("FAIL basic_flags: got %b expected 0000", flags); end
    tick();
  endtask

  task automatic test_cond_eq();
    in_valid = 1'b1; in_setflags = 1'b1; in_cond = 4'd0;
    tick();
    in_valid = 1'b0; in_setflags = 1'b0; wb_flag_valid = 1'b1; wb_flags = 4'b0100;
    tick();
    wb_flag_valid = 1'b0;
    checks++; if (flags !== 4'b0100) begin errors++; $display("FAIL eq_flags_z: got %b expected 0100", flags); end
    in_valid = 1'b1; in_cond = 4'd1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL eq_pass_ready: got %b expected 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || squash !== 1'b0) begin errors++; $display("FAIL eq_pass: got ov=%b sq=%b expected 1 0", out_valid, squash); end
    tick();
    in_valid = 1'b1; in_setflags = 1'b1; in_cond = 4'd0;
    tick();
    in_valid = 1'b0; in_setflags = 1'b0; wb_flag_valid = 1'b1; wb_flags = 4'b0000;
    tick();
    wb_flag_valid = 1'b0;
    in_valid = 1'b1; in_cond = 4'd1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL eq_fail_ready: got %b expected 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (squash !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL eq_fail_squash: got sq=%b ov=%b expected 1 0", squash, out_valid); end
    tick();
    checks++; if (squash !== 1'b0) begin errors++; $display("FAIL eq_squash_pulse: got %b expected 0", squash); end
  endtask

  task automatic test_hazard();
    int s0;
    s0 = m_stall;
    in_valid = 1'b1; in_setflags = 1'b1; in_cond = 4'd0; in_opcode = 4'hA;
    tick();
    in_setflags = 1'b0; in_cond = 4'd2; in_opcode = 4'd2;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hazard_block_%0d: got in_ready=%b expected 0", i, in_ready); end
      tick();
    end
    wb_flag_valid = 1'b1; wb_flags = 4'b0000;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hazard_bypass_ready: got %b expected 1", in_ready); end
    tick();
    in_valid = 1'b0; wb_flag_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_opcode !== 4'd2) begin errors++; $display("FAIL hazard_issue: got ov=%b op=%0d expected 1 2", out_valid, out_opcode); end
    checks++; if (stall_cycles !== 16'(s0 + 3)) begin errors++; $display("FAIL hazard_stall_cycles: got %0d expected %0d", stall_cycles, s0 + 3); end
    tick();
  endtask

  task automatic test_capacity();
    in_valid = 1'b1; in_setflags = 1'b1; in_cond = 4'd0;
    repeat (3) tick();
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL cap_full: got in_ready=%b expected 0", in_ready); end
    wb_flag_valid = 1'b1; wb_flags = 4'b0000;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL cap_wb_same_cycle: got in_ready=%b expected 1", in_ready); end
    tick();
    wb_flag_valid = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL cap_still_full: got in_ready=%b expected 0", in_ready); end
    in_valid = 1'b0; in_setflags = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL cap_flush_ov: got %b expected 0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_cond = 4'd0; in_opcode = 4'd3; in_a = 11; in_b = -7;
    tick();
    in_opcode = 4'd5; in_a = 100; in_b = 200;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_%0d: got %b expected 0", i, in_ready); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_a !== 11 || out_b !== -32'sd7 || out_opcode !== 4'd3) begin errors++; $display("FAIL bp_hold_%0d: got ov=%b a=%0d b=%0d op=%0d expected 1 11 -7 3", i, out_valid, out_a, out_b, out_opcode); end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_a !== 100 || out_opcode !== 4'd5) begin errors++; $display("FAIL bp_next: got a=%0d op=%0d expected 100 5", out_a, out_opcode); end
    tick();
  endtask

  task automatic test_underflow();
    wb_flag_valid = 1'b1; wb_flags = 4'b1010;
    tick();
    wb_flag_valid = 1'b0;
    checks++; if (err_underflow !== 1'b1 || flags !== 4'b1010) begin errors++; $display("FAIL underflow_set: got err=%b flags=%b expected 1 1010", err_underflow, flags); end
    tick();
    checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL underflow_sticky: got %b expected 1", err_underflow); end
  endtask

  task automatic test_flush();
    in_valid = 1'b1; in_setflags = 1'b1; in_cond = 4'd0;
    repeat (2) tick();
    in_valid = 1'b0; in_setflags = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (out_valid !== 1'b0 || squash !== 1'b0) begin errors++; $display("FAIL flush_out: got ov=%b sq=%b expected 0 0", out_valid, squash); end
    checks++; if (err_underflow !== 1'b1 || flags !== 4'b1010) begin errors++; $display("FAIL flush_keep: got err=%b flags=%b expected 1 1010", err_underflow, flags); end
    in_valid = 1'b1; in_cond = 4'd3;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_pend_cleared: got in_ready=%b expected 1", in_ready); end
    tick();
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; in_setflags = 1'b1; in_cond = 4'd0;
    tick();
    in_setflags = 1'b0; in_cond = 4'd2;
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    checks++; if ({out_valid, squash, err_underflow, flags, stall_cycles} !== '0) begin errors++; $display("FAIL rstmid_state: got ov=%b sq=%b err=%b flags=%b stall=%0d expected all 0", out_valid, squash, err_underflow, flags, stall_cycles); end
    checks++; if ({out_opcode, out_a, out_b} !== '0) begin errors++; $display("FAIL rstmid_data: got %h/%h/%h expected 0", out_opcode, out_a, out_b); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_pend: got in_ready=%b expected 1", in_ready); end
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++; if (squash !== 1'b0) begin errors++; $display("FAIL rstmid_no_squash: got %b expected 0", squash); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      in_valid    = ($urandom % 4) != 0;
      in_cond     = (($urandom % 4) != 0) ? 4'($urandom_range(0, 8)) : 4'($urandom_range(0, 15));
      in_setflags = ($urandom % 3) == 0;
      in_opcode   = 4'($urandom);
      in_a        = $urandom;
      in_b        = $urandom;
      out_ready   = ($urandom % 4) != 0;
      wb_flag_valid = (m_pend > 0) ? (($urandom % 3) == 0) : (($urandom % 25) == 0);
      wb_flags    = 4'($urandom);
      flush       = ($urandom % 40) == 0;
      #1;
      checks++; if (in_ready !== m_ready()) begin errors++; $display("FAIL rnd_in_ready @%0d: got %b expected %b", i, in_ready, m_ready()); end
      tick();
      checks++; if (out_valid !== m_ov) begin errors++; $display("FAIL rnd_out_valid @%0d: got %b expected %b", i, out_valid, m_ov); end
      checks++; if ({out_opcode, out_a, out_b, out_setflags} !== {m_op, m_a, m_b, m_sf}) begin errors++; $display("FAIL rnd_out_data @%0d: got %h %h %h %b expected %h %h %h %b", i, out_opcode, out_a, out_b, out_setflags, m_op, m_a, m_b, m_sf); end
      checks++; if ({squash, err_underflow, flags} !== {m_sq, m_err, m_flags}) begin errors++; $display("FAIL rnd_status @%0d: got sq=%b err=%b flags=%b expected %b %b %b", i, squash, err_underflow, flags, m_sq, m_err, m_flags); end
      checks++; if (stall_cycles !== 16'(m_stall)) begin errors++; $display("FAIL rnd_stall @%0d: got %0d expected %0d", i, stall_cycles, m_stall); end
    end
    idle();
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_pass();
    test_cond_eq();
    test_hazard();
    test_capacity();
    test_backpressure();
    test_underflow();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cond_issue_stage.md
Name: cond_issue_stage

Overview:
- Pipeline stage directly upstream of the ALU/CMP datapath.
- Holds the architectural NZCV flag register and evaluates each incoming instruction's 4-bit condition code against it.
- Forwards passing instructions to the ALU over a valid/ready handshake and squashes failing ones.
- Stalls conditional instructions while a flag-setting instruction is still in flight. Flag results return from the ALU on a writeback port.

Parameters:
- DATA_W, 32, operand width.
- MAX_PEND, 3, maximum number of in-flight flag-setting instructions (counter width clog2(MAX_PEND+1)).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_cond  in  4  condition: 0000 AL, 0001 EQ, 0010 GT, 0011 LT, 0100 GE, 0101 LE, 0110 HI, 0111 LO, 1000 HS; 1001-1111 never.
- in_setflags  in  1  instruction writes NZCV.
- in_opcode  in  4  ALU opcode, passed through.
- in_a, in_b  in  DATA_W  signed operands, passed through.
- out_valid  out  1  instruction presented to the ALU.
- out_ready  in  1  ALU accepts.
- out_opcode  out  4  registered opcode.
- out_a, out_b  out  DATA_W  registered operands.
- out_setflags  out  1  registered setflags.
- squash  out  1  one-cycle pulse: the last accepted instruction failed its condition.
- wb_flag_valid  in  1  ALU returns flags for the oldest pending setflags instruction.
- wb_flags  in  4  returned flags [N=3, Z=2, C=1, V=0].
- flags  out  4  architectural NZCV register.
- stall_cycles  out  16  saturating count of hazard-stall cycles.
- err_underflow  out  1  sticky: wb_flag_valid arrived with no pending writer.

Behaviour:
- Reset (rst_n low, asynchronous):
  - flags=0000, pend_cnt=0, out_valid=0, out_* data=0, squash=0, stall_cycles=0, err_underflow=0.
  - State goes to IDLE.
- Flag writeback:
  - On wb_flag_valid, flags<=wb_flags.
  - eff_flags = wb_flag_valid ? wb_flags : flags (same-cycle bypass).
  - eff_pend = pend_cnt - (wb_flag_valid && pend_cnt!=0).
- Condition pass, evaluated on eff_flags:
  - AL: 1.
  - EQ: Z.
  - GT: !Z && N==V.
  - LT: N!=V.
  - GE: N==V.
  - LE: Z || N!=V.
  - HI: C && !Z.
  - LO: !C.
  - HS: C.
  - 1001-1111: 0.
- Hazard is in_valid && in_cond!=AL && eff_pend!=0.
- Capacity stall is in_setflags && eff_pend==MAX_PEND.
- in_ready = !flush && (!out_valid || out_ready) && !hazard && !capacity stall. in_ready may depend on the in_* fields.
- Accept (in_valid && in_ready), latency 1:
  - Pass: out_* <= in_*, out_valid<=1. If in_setflags, pend_cnt increments.
  - Fail: out_valid<=0 (unless held), squash<=1 for one cycle, no pend_cnt increment.
- Counter update:
  - Increment and writeback decrement in the same cycle leave pend_cnt unchanged.
  - Decrement at 0 keeps pend_cnt at 0 and sets err_underflow.
- Output hold: while out_valid && !out_ready, out_* stay stable. out_valid clears after a handshake when no new pass is accepted.
- FSM (registered):
  - IDLE (out_valid=0): pass -> ISSUED; hazard -> HAZARD; otherwise stay.
  - ISSUED (out_valid=1): out_ready && no new pass -> IDLE; new pass -> ISSUED; hazard -> HAZARD.
  - HAZARD: entered when in_valid is held but blocked by hazard. Each cycle there increments stall_cycles, saturating at 16'hFFFF. Leaves when eff_pend==0 and the instruction is accepted -> ISSUED/IDLE.
  - out_valid is a register independent of the HAZARD encoding; HAZARD with out_valid=1 must still complete the output handshake.
- Flush (synchronous, priority over accept):
  - Next cycle: out_valid=0, pend_cnt=0, squash=0, state IDLE.
  - flags retain their value, still updated by a same-cycle wb_flag_valid.
  - stall_cycles and err_underflow are kept.
- Reset mid-transaction: all state is cleared immediately and no squash pulse is produced.

Test Plan:
- Reset, then AL ADD a=5 b=3 with out_ready=1 -> out_valid=1 one cycle later with out_a=5, out_b=3; flags=0000.
- flags=0100 (Z), cond EQ -> passes. Then flags=0000, cond EQ -> in_ready=1, squash=1 next cycle, out_valid stays 0, pend_cnt unchanged.
- Issue setflags CMP, then a GT instruction next cycle:
  - in_ready=0 and HAZARD for 3 cycles; stall_cycles=3.
  - wb_flag_valid with wb_flags=0000 -> GT accepted in that same cycle via bypass, and out_valid=1.
- Three setflags instructions issued with no writeback -> pend_cnt=3; a 4th setflags gets in_ready=0. A wb pulse in the same cycle allows the 4th to be accepted and pend_cnt stays 3.
- out_ready=0 for 4 cycles after a pass -> out_* stable and in_ready=0; out_ready=1 -> handshake, next instruction accepted.
- wb_flag_valid with pend_cnt=0 -> err_underflow=1 (sticky) and flags updated.
- flush with pend_cnt=2 -> next cycle pend_cnt=0 and out_valid=0.
- rst_n asserted mid-stall -> all outputs return to reset values asynchronously.
